// File: rtl/seven_seg_scanner_if.sv
// Signal bundle between score logic (master) and the seven-segment scanner (slave).
// Carries the digit data and load strobe in, and the board pin drive and scan status out.
interface seven_seg_scanner_if #(
  parameter int unsigned NUM_DIGITS = 4
) ();
  localparam int unsigned IdxW = $clog2(NUM_DIGITS);

  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    lz_suppress;
  logic                    load;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  logic [IdxW-1:0]         scan_idx;
  logic                    frame_done;

  modport master (
    output value, dp_in, digit_en, blink_mask, lz_suppress, load,
    input  seg, dp, an, scan_idx, frame_done
  );

  modport slave (
    input  value, dp_in, digit_en, blink_mask, lz_suppress, load,
    output seg, dp, an, scan_idx, frame_done
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment scanner with frame-aligned double buffering, per-digit
// blanking, leading-zero suppression, blink, decimal points and an anti-ghosting guard window.
module seven_seg_scanner #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned GUARD          = 16,
  parameter int unsigned BLINK_FRAMES   = 64,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input logic                i_clk,
  input logic                i_rst_n,
  seven_seg_scanner_if.slave io_bus
);
  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);
  localparam int unsigned SlotW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FrameW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [6:0]            SegOff = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DpOff  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AnOff  = AN_ACTIVE_LOW ? '1 : '0;

  // Active-low segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [SlotW-1:0]  r_slot_cnt;
  logic [IdxW-1:0]   r_scan_idx;
  logic [FrameW-1:0] r_frame_cnt;
  logic              r_blink_off;

  logic [4*NUM_DIGITS-1:0] r_pend_value, r_act_value;
  logic [NUM_DIGITS-1:0]   r_pend_dp, r_act_dp;
  logic [NUM_DIGITS-1:0]   r_pend_en, r_act_en;
  logic [NUM_DIGITS-1:0]   r_pend_blink, r_act_blink;
  logic                    r_pend_lz, r_act_lz;
  logic                    r_pend_valid;

  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_an;

  logic                  w_slot_last, w_idx_last, w_frame_done, w_in_guard;
  logic [3:0]            w_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_lz_blank;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic                  w_blink_hide, w_seg_lit, w_dp_lit;
  logic [6:0]            w_dec;
  logic [6:0]            w_seg_d;
  logic                  w_dp_d;
  logic [NUM_DIGITS-1:0] w_an_d;

  assign w_slot_last  = (r_slot_cnt == SlotW'(SCAN_DIV - 1));
  assign w_idx_last   = (r_scan_idx == IdxW'(NUM_DIGITS - 1));
  assign w_frame_done = w_slot_last && w_idx_last;
  assign w_in_guard   = (GUARD != 0) && (r_slot_cnt < SlotW'(GUARD));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_slot_cnt  <= '0;
      r_scan_idx  <= '0;
      r_frame_cnt <= '0;
      r_blink_off <= 1'b0;
    end else begin
      if (w_slot_last) begin
        r_slot_cnt <= '0;
        r_scan_idx <= w_idx_last ? '0 : r_scan_idx + IdxW'(1);
      end else begin
        r_slot_cnt <= r_slot_cnt + SlotW'(1);
      end
      if (w_frame_done) begin
        if (r_frame_cnt == FrameW'(BLINK_FRAMES - 1)) begin
          r_frame_cnt <= '0;
          r_blink_off <= ~r_blink_off;
        end else begin
          r_frame_cnt <= r_frame_cnt + FrameW'(1);
        end
      end
    end
  end

  // Active only changes on the last cycle of a frame, so a frame never shows mixed data;
  // a load on that same cycle lands in pending and waits for the next frame boundary.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_value <= '0;
      r_pend_dp    <= '0;
      r_pend_en    <= '0;
      r_pend_blink <= '0;
      r_pend_lz    <= 1'b0;
      r_pend_valid <= 1'b0;
      r_act_value  <= '0;
      r_act_dp     <= '0;
      r_act_en     <= '0;
      r_act_blink  <= '0;
      r_act_lz     <= 1'b0;
    end else begin
      if (w_frame_done && r_pend_valid) begin
        r_act_value <= r_pend_value;
        r_act_dp    <= r_pend_dp;
        r_act_en    <= r_pend_en;
        r_act_blink <= r_pend_blink;
        r_act_lz    <= r_pend_lz;
      end
      if (io_bus.load) begin
        r_pend_value <= io_bus.value;
        r_pend_dp    <= io_bus.dp_in;
        r_pend_en    <= io_bus.digit_en;
        r_pend_blink <= io_bus.blink_mask;
        r_pend_lz    <= io_bus.lz_suppress;
        r_pend_valid <= 1'b1;
      end else if (w_frame_done) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_nib[i] = r_act_value[4*i +: 4];
    end
  end

  // A digit is a leading zero when it and every digit above it hold nibble 0.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    w_lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero    = upper_zero & (w_nib[i] == 4'h0);
      w_lz_blank[i] = r_act_lz & upper_zero & (i != 0);
    end
  end

  assign w_onehot     = {{(NUM_DIGITS - 1){1'b0}}, 1'b1} << r_scan_idx;
  assign w_blink_hide = r_blink_off & r_act_blink[r_scan_idx];
  assign w_seg_lit    = r_act_en[r_scan_idx] & ~w_blink_hide & ~w_lz_blank[r_scan_idx];
  assign w_dp_lit     = r_act_dp[r_scan_idx] & r_act_en[r_scan_idx] & ~w_blink_hide;
  assign w_dec        = hex_to_seg(w_nib[r_scan_idx]);

  always_comb begin
    w_seg_d = SegOff;
    w_dp_d  = DpOff;
    w_an_d  = AnOff;
    if (!w_in_guard) begin
      w_an_d = AN_ACTIVE_LOW ? ~w_onehot : w_onehot;
      if (w_seg_lit) begin
        w_seg_d = SEG_ACTIVE_LOW ? w_dec : ~w_dec;
      end
      if (w_dp_lit) begin
        w_dp_d = ~DpOff;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_seg <= SegOff;
      r_dp  <= DpOff;
      r_an  <= AnOff;
    end else begin
      r_seg <= w_seg_d;
      r_dp  <= w_dp_d;
      r_an  <= w_an_d;
    end
  end

  assign io_bus.seg        = r_seg;
  assign io_bus.dp         = r_dp;
  assign io_bus.an         = r_an;
  assign io_bus.scan_idx   = r_scan_idx;
  assign io_bus.frame_done = w_frame_done;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: each frame's expected digit image is queued with the
// stimulus and compared cycle by cycle against the scanned pins.
module tb_seven_seg_scanner;
  localparam int unsigned Digits  = 4;
  localparam int unsigned ScanDiv = 8;
  localparam int unsigned Guard   = 2;
  localparam int unsigned Blink   = 2;
  localparam int          FrameCy = Digits * ScanDiv;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [3:0]  blink;
    logic        lz;
  } stim_t;

  typedef struct packed {
    logic [3:0][6:0] seg;
    logic [3:0]      dp;
  } img_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   exp_frame_n;
  img_t exp_q[$];
  logic [6:0] seg_tab [16];

  seven_seg_scanner_if #(.NUM_DIGITS(Digits)) bus ();

  seven_seg_scanner #(
    .NUM_DIGITS    (Digits),
    .SCAN_DIV      (ScanDiv),
    .GUARD         (Guard),
    .BLINK_FRAMES  (Blink),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) u_dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic img_t model(input stim_t s, input bit blink_off);
    img_t m;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] upper;
      logic        hide;
      logic        lzb;
      upper    = s.value >> (4 * i);
      hide     = s.blink[i] && blink_off;
      lzb      = s.lz && (i != 0) && (upper == 16'h0);
      m.seg[i] = (s.en[i] && !hide && !lzb) ? seg_tab[s.value[4*i +: 4]] : 7'h7F;
      m.dp[i]  = (s.dp[i] && s.en[i] && !hide) ? 1'b0 : 1'b1;
    end
    return m;
  endfunction

  task automatic push_exp(input stim_t shown);
    exp_q.push_back(model(shown, ((exp_frame_n / Blink) % 2) == 1));
    exp_frame_n++;
  endtask

  task automatic drive_load(input stim_t s);
    bus.value       = s.value;
    bus.dp_in       = s.dp;
    bus.digit_en    = s.en;
    bus.blink_mask  = s.blink;
    bus.lz_suppress = s.lz;
    bus.load        = 1'b1;
  endtask

  // Observes one full frame starting at slot 0 of digit 0; optional loads at cycles ld0/ld1.
  task automatic run_frame(input int ld0, input stim_t d0, input int ld1, input stim_t d1);
    img_t       e;
    int         d;
    int         s;
    logic [3:0] an_e;
    logic [7:0] sd_e;
    check_eq("queue_len", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    for (int c = 0; c < FrameCy; c++) begin
      d = c / ScanDiv;
      s = c % ScanDiv;
      @(negedge clk);
      check_eq($sformatf("frame_done c%0d", c), 32'(bus.frame_done), 32'(c == FrameCy - 1));
      if (s == 0) check_eq($sformatf("scan_idx d%0d", d), 32'(bus.scan_idx), 32'(d));
      if (c == ld0) drive_load(d0);
      else if (c == ld1) drive_load(d1);
      @(posedge clk);
      #1;
      bus.load = 1'b0;
      if (s < Guard) begin
        an_e = 4'hF;
        sd_e = 8'hFF;
      end else begin
        an_e = ~(4'b0001 << d);
        sd_e = {e.seg[d], e.dp[d]};
      end
      check_eq($sformatf("an f%0d d%0d s%0d", exp_frame_n, d, s), 32'(bus.an), 32'(an_e));
      check_eq($sformatf("segdp f%0d d%0d s%0d", exp_frame_n, d, s),
               32'({bus.seg, bus.dp}), 32'(sd_e));
    end
  endtask

  initial begin
    stim_t z, a, l1, l2, l3, h1, h2, b, cb;
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    n_checks    = 0;
    n_fail      = 0;
    exp_frame_n = 0;
    z  = '0;
    a  = '{value: 16'h12AF, dp: 4'b0000, en: 4'hF, blink: 4'h0, lz: 1'b0};
    l1 = '{value: 16'h0040, dp: 4'b0000, en: 4'hF, blink: 4'h0, lz: 1'b1};
    l2 = '{value: 16'h0000, dp: 4'b0001, en: 4'hF, blink: 4'h0, lz: 1'b1};
    l3 = '{value: 16'h1040, dp: 4'b0000, en: 4'b0111, blink: 4'h0, lz: 1'b1};
    h1 = '{value: 16'h1111, dp: 4'b0000, en: 4'hF, blink: 4'h0, lz: 1'b0};
    h2 = '{value: 16'h2222, dp: 4'b0000, en: 4'hF, blink: 4'h0, lz: 1'b0};
    b  = '{value: 16'h89BD, dp: 4'b0100, en: 4'b1011, blink: 4'h0, lz: 1'b0};
    cb = '{value: 16'h5C6E, dp: 4'b0001, en: 4'hF, blink: 4'b0001, lz: 1'b0};

    bus.value = '0; bus.dp_in = '0; bus.digit_en = '0; bus.blink_mask = '0;
    bus.lz_suppress = 1'b0; bus.load = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst seg", 32'(bus.seg), 32'h7F);
    check_eq("rst dp", 32'(bus.dp), 32'h1);
    check_eq("rst an", 32'(bus.an), 32'hF);
    check_eq("rst frame_done", 32'(bus.frame_done), 32'h0);
    check_eq("rst scan_idx", 32'(bus.scan_idx), 32'h0);
    rst_n = 1'b1;

    push_exp(z);  run_frame(5, a, -1, z);
    push_exp(a);  run_frame(10, l1, -1, z);
    push_exp(l1); run_frame(3, l2, -1, z);
    push_exp(l2); run_frame(6, l3, -1, z);
    push_exp(l3); run_frame(4, h1, 20, h2);
    push_exp(h2); run_frame(FrameCy - 1, b, -1, z);
    push_exp(h2); run_frame(FrameCy - 1, cb, -1, z);
    push_exp(b);  run_frame(-1, z, -1, z);
    for (int f = 0; f < 5; f++) begin
      push_exp(cb);
      run_frame(-1, z, -1, z);
    end

    // Mid-slot asynchronous reset while digit 1 is lit.
    repeat (11) @(posedge clk);
    #1;
    check_eq("pre-rst an", 32'(bus.an), 32'h0000000D);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async rst seg", 32'(bus.seg), 32'h7F);
    check_eq("async rst dp", 32'(bus.dp), 32'h1);
    check_eq("async rst an", 32'(bus.an), 32'hF);
    check_eq("async rst scan_idx", 32'(bus.scan_idx), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_frame_n = 0;
    push_exp(z); run_frame(3, a, -1, z);
    push_exp(a); run_frame(-1, z, -1, z);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
